// File: rtl/te_transmission_pipe.sv
// Transmission estimate t = max(1 - min_c(Pc * w/Ac), T0) for the dehaze path.
// Three register stages with per-stage valid/ready; empty stages fill even while downstream stalls.
module te_transmission_pipe #(
    parameter int PIX_W  = 8,
    parameter int INV_W  = 16,
    parameter int FRAC_W = 14,
    parameter int NUM_CH = 3,
    parameter int SAT_EN = 1,
    parameter int T0     = 1638
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ac_load,
    input  logic [NUM_CH*INV_W-1:0]   inv_ac_in,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_CH*PIX_W-1:0]   in_pix,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FRAC_W-1:0]         trans,
    output logic                      sat_flag
);

    localparam int P_W = PIX_W + FRAC_W;
    localparam logic [FRAC_W-1:0] ONES = '1;
    localparam logic [FRAC_W-1:0] T0_V = FRAC_W'(T0);

    logic [NUM_CH*INV_W-1:0] r_inv;
    logic                    r_v1, r_v2, r_v3;
    logic [P_W-1:0]          r_p [NUM_CH];
    logic [FRAC_W-1:0]       r_m;
    logic                    r_sf;
    logic [FRAC_W-1:0]       r_trans;
    logic                    r_sat;

    logic                    w_adv1, w_adv2, w_adv3;
    logic [P_W-1:0]          w_p [NUM_CH];
    logic [FRAC_W-1:0]       w_q [NUM_CH];
    logic [NUM_CH-1:0]       w_ovf;
    logic [FRAC_W-1:0]       w_m;
    logic                    w_sf;
    logic [FRAC_W-1:0]       w_d;
    logic [FRAC_W-1:0]       w_t;

    assign w_adv3   = !r_v3 || out_ready;
    assign w_adv2   = !r_v2 || w_adv3;
    assign w_adv1   = !r_v1 || w_adv2;
    assign in_ready = w_adv1;

    genvar g;
    for (g = 0; g < NUM_CH; g++) begin : g_ch
        logic [FRAC_W-1:0] w_iv;
        // Only the top FRAC_W bits of w/Ac take part in the product.
        assign w_iv     = r_inv[g*INV_W + (INV_W-FRAC_W) +: FRAC_W];
        assign w_p[g]   = {{FRAC_W{1'b0}}, in_pix[g*PIX_W +: PIX_W]} * {{PIX_W{1'b0}}, w_iv};
        assign w_ovf[g] = |r_p[g][P_W-1:FRAC_W];
        assign w_q[g]   = ((SAT_EN != 0) && w_ovf[g]) ? ONES : r_p[g][FRAC_W-1:0];
        if (INV_W > FRAC_W) begin : g_lo
            logic w_unused_lo;
            assign w_unused_lo = |r_inv[g*INV_W +: INV_W-FRAC_W];
        end
    end

    always_comb begin
        w_m = w_q[0];
        for (int c = 1; c < NUM_CH; c++) begin
            if (w_q[c] < w_m) w_m = w_q[c];
        end
    end

    assign w_sf = |w_ovf;
    assign w_d  = ONES - r_m;
    assign w_t  = (w_d < T0_V) ? T0_V : w_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inv   <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_m     <= '0;
            r_sf    <= 1'b0;
            r_trans <= '0;
            r_sat   <= 1'b0;
        end else begin
            if (ac_load) r_inv <= inv_ac_in;
            if (w_adv1) begin
                r_v1 <= in_valid;
                if (in_valid) begin
                    for (int c = 0; c < NUM_CH; c++) r_p[c] <= w_p[c];
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_m  <= w_m;
                    r_sf <= w_sf;
                end
            end
            // Output registers only change on an advance, so a stalled result is held.
            if (w_adv3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_trans <= w_t;
                    r_sat   <= r_sf;
                end
            end
        end
    end

    assign out_valid = r_v3;
    assign trans     = r_trans;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_te_transmission_pipe.sv
// Directed bench: defaults, saturation/truncation, floor, backpressure, ac_load timing, reset.
module tb_te_transmission_pipe;

    logic        clk;
    logic        rst;
    logic        ac_load;
    logic [47:0] inv_ac_in;
    logic        in_valid;
    logic [23:0] in_pix;
    logic        out_ready;

    logic        in_ready,  out_valid,  sat_flag;
    logic [13:0] trans;
    logic        in_ready_a, out_valid_a, sat_flag_a;
    logic [13:0] trans_a;
    logic        in_ready_b, out_valid_b, sat_flag_b;
    logic [13:0] trans_b;

    int total = 0;
    int bad   = 0;

    te_transmission_pipe dut (
        .clk(clk), .rst(rst), .ac_load(ac_load), .inv_ac_in(inv_ac_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .out_valid(out_valid), .out_ready(out_ready), .trans(trans), .sat_flag(sat_flag)
    );

    te_transmission_pipe #(.SAT_EN(1), .T0(0)) dut_a (
        .clk(clk), .rst(rst), .ac_load(ac_load), .inv_ac_in(inv_ac_in),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_pix(in_pix),
        .out_valid(out_valid_a), .out_ready(out_ready), .trans(trans_a), .sat_flag(sat_flag_a)
    );

    te_transmission_pipe #(.SAT_EN(0), .T0(0)) dut_b (
        .clk(clk), .rst(rst), .ac_load(ac_load), .inv_ac_in(inv_ac_in),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_pix(in_pix),
        .out_valid(out_valid_b), .out_ready(out_ready), .trans(trans_b), .sat_flag(sat_flag_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_inv(input logic [15:0] v);
        ac_load   = 1'b1;
        inv_ac_in = {v, v, v};
        tick();
        ac_load   = 1'b0;
    endtask

    // One beat with out_ready=1; result must show on the third sample counting the accept edge.
    task automatic run_one(input string tag, input logic [23:0] pix,
                           input int t0, input int s0, input int ta, input int sa,
                           input int tb, input int sb);
        in_pix   = pix;
        in_valid = 1'b1;
        #1;
        chk({tag, "_rdy"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        tick();
        chk({tag, "_lat2"}, out_valid, 0);
        tick();
        chk({tag, "_vld"}, out_valid, 1);
        chk({tag, "_t"}, trans, t0);
        chk({tag, "_s"}, sat_flag, s0);
        chk({tag, "_vld_a"}, out_valid_a, 1);
        chk({tag, "_t_a"}, trans_a, ta);
        chk({tag, "_s_a"}, sat_flag_a, sa);
        chk({tag, "_t_b"}, trans_b, tb);
        chk({tag, "_s_b"}, sat_flag_b, sb);
        tick();
        chk({tag, "_drain"}, out_valid, 0);
    endtask

    task automatic get_out(input string tag, input int exp_t);
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (out_valid) begin
                seen = 1;
                chk(tag, trans, exp_t);
            end
            tick();
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    function automatic int bp_model(input int p0, input int p1, input int p2);
        int m;
        int d;
        m = (p0 < p1) ? p0 : p1;
        m = (m < p2) ? m : p2;
        d = 16383 - m * 61;
        return (d < 1638) ? 1638 : d;
    endfunction

    initial begin
        int q[$];
        int sent;
        int rcv;
        logic [13:0] held;
        bit held_v;
        bit acc;
        int p0, p1, p2;

        rst = 1'b1; ac_load = 1'b0; inv_ac_in = '0; in_valid = 1'b0;
        in_pix = '0; out_ready = 1'b1;
        tick();
        tick();
        chk("rst_ov", out_valid, 0);
        chk("rst_trans", trans, 0);
        chk("rst_sat", sat_flag, 0);
        rst = 1'b0;
        tick();
        chk("rst_rdy", in_ready, 1);

        // 1: defaults, iv=61
        load_inv(16'h00F4);
        run_one("t1", {8'd150, 8'd200, 8'd128}, 8575, 0, 8575, 0, 8575, 0);

        // 2 and 3: iv=16383
        load_inv(16'hFFFF);
        run_one("t2sat", {8'd2, 8'd2, 8'd2}, 1638, 1, 0, 1, 1, 1);
        run_one("t3floor", {8'd1, 8'd1, 8'd1}, 1638, 0, 0, 0, 0, 0);

        // 4: backpressure, out_ready low for cycles 2..8
        load_inv(16'h00F4);
        sent = 0; rcv = 0; held_v = 0;
        for (int cyc = 0; cyc < 60 && rcv < 10; cyc++) begin
            out_ready = !(cyc >= 2 && cyc <= 8);
            p0 = 30 + 20 * sent; p1 = 250 - 15 * sent; p2 = 90 + 3 * sent;
            in_valid = (sent < 10);
            in_pix = {p2[7:0], p1[7:0], p0[7:0]};
            #1;
            acc = in_valid && in_ready;
            if (cyc == 8) begin
                chk("bp_rdy_low", in_ready, 0);
                chk("bp_inflight", sent - rcv, 3);
            end
            if (out_valid && held_v) chk("bp_hold", trans, held);
            if (out_valid && out_ready) begin
                chk("bp_data", trans, q.pop_front());
                rcv++;
            end
            held_v = out_valid && !out_ready;
            held   = trans;
            if (acc) begin
                q.push_back(bp_model(p0, p1, p2));
                sent++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", rcv, 10);

        // 5: beat accepted on the ac_load edge uses the old iv
        in_pix    = {8'd10, 8'd10, 8'd10};
        in_valid  = 1'b1;
        ac_load   = 1'b1;
        inv_ac_in = {3{16'h0F00}};
        tick();
        ac_load = 1'b0;
        tick();
        in_valid = 1'b0;
        get_out("t5_old", 15773);
        get_out("t5_new", 6783);

        // 6: reset with three beats in flight
        out_ready = 1'b0;
        in_pix    = {8'd5, 8'd5, 8'd5};
        in_valid  = 1'b1;
        tick();
        tick();
        tick();
        in_valid = 1'b0;
        chk("t6_full", out_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_ov", out_valid, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_stale", {out_valid, out_valid_a, out_valid_b}, 0);
        end
        run_one("t6_post", {8'd100, 8'd100, 8'd100}, 16383, 0, 16383, 0, 16383, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/te_transmission_pipe.md
Name: te_transmission_pipe

Overview:
Parametrised successor to the single-channel transmission-estimation multiplier. Takes NUM_CH filtered pixel channels and per-channel scaled inverse atmospheric light (ω/Ac, Q0.INV_W). Per channel it computes Pc·(ω/Ac), saturates or truncates to Q0.FRAC_W, takes the channel minimum, and produces transmission t = 1 − min, floored at T0. It sits between the dark-channel filter and the scene-recovery divider, and uses a valid/ready stream with per-stage bubble collapsing.

Parameters:
PIX_W, 8, filtered pixel width (unsigned integer)
INV_W, 16, inverse-Ac width, Q0.INV_W; INV_W >= FRAC_W
FRAC_W, 14, fraction bits of product and transmission
NUM_CH, 3, channel count (1..4)
SAT_EN, 1, 1 = saturate overflowing product to all-ones; 0 = keep low FRAC_W bits (legacy truncation)
T0, 1638, transmission floor in Q0.FRAC_W (0.1 at FRAC_W=14)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ac_load  in  1  latch inv_ac_in into the internal inverse-Ac registers
inv_ac_in  in  NUM_CH*INV_W  ω/Ac per channel, channel 0 in LSBs, Q0.INV_W
in_valid  in  1  pixel beat valid
in_ready  out  1  block can accept a beat
in_pix  in  NUM_CH*PIX_W  filtered pixel per channel, channel 0 in LSBs
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
trans  out  FRAC_W  transmission, Q0.FRAC_W
sat_flag  out  1  at least one channel product overflowed Q0.FRAC_W for this beat

Behaviour:
- Reset: all stage valids 0; out_valid=0, trans=0, sat_flag=0; inverse-Ac registers=0; in_ready=1 the cycle after reset deasserts.
- ac_load: the registers update on the clock edge where ac_load=1. The new value applies to beats accepted on later edges. A beat accepted on the same edge uses the old value. ac_load is independent of the handshake.
- Inverse operand: iv_c = inv_reg_c[INV_W-1 : INV_W-FRAC_W] (drop the low INV_W-FRAC_W bits).
- S1 (accept edge): p_c = in_pix_c * iv_c. The result is PIX_W+FRAC_W bits, Q(PIX_W).FRAC_W, exact, with no rounding.
- S2:
  - ovf_c = |p_c[PIX_W+FRAC_W-1:FRAC_W].
  - q_c = (SAT_EN && ovf_c) ? all-ones : p_c[FRAC_W-1:0].
  - m = min over c of q_c. Unsigned compare; on a tie either channel gives the same value.
  - sflag = OR of ovf_c. It is set even when SAT_EN=0.
- S3: d = (2^FRAC_W − 1) − m; trans = (d < T0) ? T0 : d; sat_flag = sflag.
- Latency: 3 cycles from accept edge to out_valid with no backpressure. Throughput is 1 beat/cycle.
- Handshake per stage k: adv_k = !v_k || adv_(k+1), where adv_4 = out_ready. in_ready = adv_1.
  - Bubbles collapse: an empty stage accepts even while downstream stalls.
  - A stage holding valid data keeps its data and valid stable until it advances.
  - out_valid=1 with out_ready=0 holds trans and sat_flag unchanged.
- A beat transfers on in_valid && in_ready. No beat is dropped or duplicated. With out_ready held 0, exactly 3 beats are accepted, then in_ready=0.
- Simultaneous accept and emit on the same edge is allowed at full rate.
- Reset mid-operation: all in-flight beats are discarded, valids clear on that edge, and inverse registers clear. No output appears for discarded beats.
- in_ready is combinational from out_ready and the stage valids. There are no other combinational input-to-output paths.
- Multipliers are unsigned. No signed arithmetic anywhere.

Test Plan:
1. Defaults. ac_load with all channels 0x00F4 (ω=0.95, Ac=255; iv=61). Pixels {128,200,150}, out_ready=1.
   -> products 7808, 12200, 9150; m=7808; trans=8575, sat_flag=0, exactly 3 cycles after accept.
2. Saturation, SAT_EN=1, T0=0. inv=0xFFFF (iv=16383), all pixels=2.
   -> p=32766, ovf=1, q=16383; trans=0, sat_flag=1.
   Same stimulus with SAT_EN=0 -> q=16382, trans=1, sat_flag=1.
3. Floor. Defaults, inv=0xFFFF, pixels {1,1,1}.
   -> m=16383, d=0, trans=1638 (T0), sat_flag=0.
4. Backpressure. Stream 10 beats with distinct pixels, out_ready=0 for cycles 2–8, then 1.
   -> only 3 beats accepted while stalled, in_ready=0 thereafter. All 10 results emerge in order with correct values. Held output stays stable while stalled.
5. ac_load timing. ac_load changes inv from 0x00F4 to 0x0F00 on the same edge a beat is accepted.
   -> that beat uses iv=61; the next beat uses iv=960.
6. Mid-stream reset. rst pulses with 3 beats in flight.
   -> out_valid=0 next cycle, no stale beats emerge, inverse registers read 0. A post-reset beat with pixel 100 gives trans=16383.
